serial_sum_collector: RTL

- Downstream stage of the serial adder FSM.
- Watches the adder's start strobe, captures its LSB-first sum stream plus the final carry (flagged by done), and assembles a parallel (WIDTH+1)-bit result.
- Presents the result on a registered valid/ready interface to the consuming logic.
- Detects framing and overrun errors.

---
 rtl/collector_pkg.sv | 15 +
 rtl/serial_sum_collector.sv | 138 +++++++++++++
 2 files changed

// File: rtl/collector_pkg.sv
// Shared types and sizing helpers for the serial sum collector.
package collector_pkg;

    typedef enum logic [1:0] {
        C_IDLE,
        C_COLLECT,
        C_HOLD
    } coll_state_ty;

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sum_collector.sv
// Collects an LSB-first serial sum plus carry into a parallel result and
// offers it on a registered valid/ready interface with sticky error flags.
module serial_sum_collector
    import collector_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             sum_in,
    input  logic             done_in,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [WIDTH:0]   result,
    output logic             out_valid,
    output logic             busy,
    output logic             err_frame,
    output logic             err_ovr
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    coll_state_ty      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   skip_q, skip_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH:0]    result_q, result_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_frame_q, err_frame_d;
    logic              err_ovr_q, err_ovr_d;
    logic              frame_evt, ovr_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        frame_evt = 1'b0;
        ovr_evt   = 1'b0;
        // skip_q counts down the remaining cycles of a frame dropped on overrun
        skip_d    = (skip_q != '0 && !done_in) ? skip_q - 1'b1 : '0;

        unique case (state_q)
            C_IDLE: begin
                if (st) begin
                    shreg_d = {sum_in, shreg_q[WIDTH-1:1]};
                    cnt_d   = CntW'(1);
                    busy_d  = 1'b1;
                    skip_d  = '0;
                    state_d = C_COLLECT;
                end else if (done_in && skip_q == '0) begin
                    frame_evt = 1'b1;
                end
            end
            C_COLLECT: begin
                if (done_in) begin
                    if (cnt_q == CntMax) begin
                        result_d = {sum_in, shreg_q};
                        valid_d  = 1'b1;
                        state_d  = C_HOLD;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = C_IDLE;
                    end
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else if (cnt_q == CntMax) begin
                    frame_evt = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = C_IDLE;
                end else begin
                    // Shift right so bit 0 lands in the LSB after WIDTH bits.
                    shreg_d = {sum_in, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            C_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = C_IDLE;
                    if (st && skip_q == '0) begin
                        shreg_d = {sum_in, shreg_q[WIDTH-1:1]};
                        cnt_d   = CntW'(1);
                        busy_d  = 1'b1;
                        state_d = C_COLLECT;
                    end
                end else if (st && skip_q == '0) begin
                    ovr_evt = 1'b1;
                    skip_d  = CntMax;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        // A new event wins over a simultaneous clear.
        err_frame_d = (err_frame_q & ~err_clr) | frame_evt;
        err_ovr_d   = (err_ovr_q & ~err_clr) | ovr_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            cnt_q       <= '0;
            skip_q      <= '0;
            shreg_q     <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_frame_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            err_frame_q <= err_frame_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign err_frame = err_frame_q;
    assign err_ovr   = err_ovr_q;

endmodule
